// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: NOP encoding, instruction field layout, PC step.
//   NOP_INST  : word injected into ID on a bubble (sll $0,$0,0)
//   *_LSB/*_W : bit positions and widths of the R/I-type instruction fields
//   PC_INCR   : sequential PC increment
package mips_pkg;

    localparam int unsigned XLEN      = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR  = 32'd4;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned IMM_W      = 16;

endpackage

// File: rtl/id_predecode.sv
// Combinational field extraction for the instruction entering the decode stage.
// Ports:
//   if_inst     : instruction word to slice
//   opcode..funct : raw field slices
//   imm_sext    : 16-bit immediate sign-extended to 32 bits
module id_predecode
    import mips_pkg::*;
(
    input  logic [31:0] if_inst,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext
);

    assign opcode   = if_inst[OPCODE_LSB +: OPCODE_W];
    assign rs       = if_inst[RS_LSB +: REG_W];
    assign rt       = if_inst[RT_LSB +: REG_W];
    assign rd       = if_inst[RD_LSB +: REG_W];
    assign shamt    = if_inst[SHAMT_LSB +: SHAMT_W];
    assign funct    = if_inst[FUNCT_LSB +: FUNCT_W];
    assign imm_sext = {{(XLEN-IMM_W){if_inst[IMM_LSB+IMM_W-1]}}, if_inst[IMM_LSB +: IMM_W]};

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush, bubble injection and a saturating
// bubble counter. Optional registered predecode fields when IF_ID_PREDECODE_EN
// is defined.
// Parameters: NOP_INST (bubble word), CNT_W (bubble counter width)
// Ports:
//   clk, rst (async, active-high)
//   if_pc, if_inst, if_valid : fetch-stage payload
//   stall, flush             : hazard controls, priority flush > stall > load
//   id_pc, id_pc_plus4, id_inst, id_valid : registered decode-stage payload
//   bubble_cnt               : saturating count of bubbles written into ID
//   id_opcode..id_imm_sext   : registered predecode fields (IF_ID_PREDECODE_EN only)
module if_id_reg #(
    parameter logic [31:0]  NOP_INST = mips_pkg::NOP_INST,
    parameter int unsigned  CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic             if_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_inst,
    output logic             id_valid,
    output logic [CNT_W-1:0] bubble_cnt
`ifdef IF_ID_PREDECODE_EN
    ,
    output logic [5:0]       id_opcode,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_shamt,
    output logic [5:0]       id_funct,
    output logic [31:0]      id_imm_sext
`endif
);

    import mips_pkg::PC_INCR;

    logic [31:0]      pc_q,    pc_d;
    logic [31:0]      pc4_q,   pc4_d;
    logic [31:0]      inst_q,  inst_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             bubble;

    // Next-state selection: flush beats stall beats load.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        bubble  = 1'b0;
        if (flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            bubble  = 1'b1;
        end else if (!stall) begin
            pc_d    = if_pc;
            pc4_d   = if_pc + PC_INCR;
            valid_d = if_valid;
            inst_d  = if_valid ? if_inst : NOP_INST;
            bubble  = !if_valid;
        end
    end

    // Saturating bubble counter; a stall holds rather than bubbles.
    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc4_q;
    assign id_inst     = inst_q;
    assign id_valid    = valid_q;
    assign bubble_cnt  = cnt_q;

`ifdef IF_ID_PREDECODE_EN
    // Decoding inst_d keeps the fields in lockstep with id_inst: it is the
    // fetched word on a valid load, NOP_INST on a bubble, and inst_q on a stall.
    logic [5:0]  opcode_d, funct_d, opcode_q, funct_q;
    logic [4:0]  rs_d, rt_d, rd_d, shamt_d, rs_q, rt_q, rd_q, shamt_q;
    logic [31:0] imm_d, imm_q;

    id_predecode u_predecode (
        .if_inst  (inst_d),
        .opcode   (opcode_d),
        .rs       (rs_d),
        .rt       (rt_d),
        .rd       (rd_d),
        .shamt    (shamt_d),
        .funct    (funct_d),
        .imm_sext (imm_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            funct_q  <= '0;
            imm_q    <= '0;
        end else begin
            opcode_q <= opcode_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
            imm_q    <= imm_d;
        end
    end

    assign id_opcode   = opcode_q;
    assign id_rs       = rs_q;
    assign id_rt       = rt_q;
    assign id_rd       = rd_q;
    assign id_shamt    = shamt_q;
    assign id_funct    = funct_q;
    assign id_imm_sext = imm_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg (default and CNT_W=4 instances).
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stall;
    logic        flush;

    logic [31:0] id_pc, id_pc_plus4, id_inst;
    logic        id_valid;
    logic [15:0] bubble_cnt;

    logic [31:0] s_pc, s_pc_plus4, s_inst;
    logic        s_valid;
    logic [3:0]  s_cnt;

`ifdef IF_ID_PREDECODE_EN
    logic [5:0]  id_opcode, id_funct, s_opcode, s_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, s_rs, s_rt, s_rd, s_shamt;
    logic [31:0] id_imm_sext, s_imm;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .stall       (stall),
        .flush       (flush),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .bubble_cnt  (bubble_cnt)
`ifdef IF_ID_PREDECODE_EN
        ,
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm_sext (id_imm_sext)
`endif
    );

    if_id_reg #(.CNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .stall       (stall),
        .flush       (flush),
        .id_pc       (s_pc),
        .id_pc_plus4 (s_pc_plus4),
        .id_inst     (s_inst),
        .id_valid    (s_valid),
        .bubble_cnt  (s_cnt)
`ifdef IF_ID_PREDECODE_EN
        ,
        .id_opcode   (s_opcode),
        .id_rs       (s_rs),
        .id_rt       (s_rt),
        .id_rd       (s_rd),
        .id_shamt    (s_shamt),
        .id_funct    (s_funct),
        .id_imm_sext (s_imm)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic v,
                         input logic st, input logic fl);
        if_pc = pc; if_inst = inst; if_valid = v; stall = st; flush = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", id_pc, 32'h0); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", id_pc_plus4, 32'h0); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=%h", id_inst, 32'h0); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        drive(32'h0000_0010, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (id_pc !== 32'h10) begin failures++; $display("FAIL load_pc got=%h exp=%h", id_pc, 32'h10); end
        checks++; if (id_pc_plus4 !== 32'h14) begin failures++; $display("FAIL load_pc4 got=%h exp=%h", id_pc_plus4, 32'h14); end
        checks++; if (id_inst !== 32'h2008_0005) begin failures++; $display("FAIL load_inst got=%h exp=%h", id_inst, 32'h2008_0005); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%b exp=1", id_valid); end
        checks++; if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL load_cnt got=%h exp=0", bubble_cnt); end
`ifdef IF_ID_PREDECODE_EN
        checks++; if (id_opcode !== 6'h08) begin failures++; $display("FAIL load_opcode got=%h exp=08", id_opcode); end
        checks++; if (id_rs !== 5'd0) begin failures++; $display("FAIL load_rs got=%0d exp=0", id_rs); end
        checks++; if (id_rt !== 5'd8) begin failures++; $display("FAIL load_rt got=%0d exp=8", id_rt); end
        checks++; if (id_funct !== 6'h05) begin failures++; $display("FAIL load_funct got=%h exp=05", id_funct); end
        checks++; if (id_imm_sext !== 32'h5) begin failures++; $display("FAIL load_imm got=%h exp=%h", id_imm_sext, 32'h5); end
`endif
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_0100 + 32'(i * 4), 32'hABCD_0000 + 32'(i), i[0], 1'b1, 1'b0);
            tick();
            checks++; if (id_pc !== 32'h10) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, id_pc, 32'h10); end
            checks++; if (id_pc_plus4 !== 32'h14) begin failures++; $display("FAIL stall_pc4[%0d] got=%h exp=%h", i, id_pc_plus4, 32'h14); end
            checks++; if (id_inst !== 32'h2008_0005) begin failures++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, id_inst, 32'h2008_0005); end
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, id_valid); end
            checks++; if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL stall_cnt[%0d] got=%h exp=0", i, bubble_cnt); end
`ifdef IF_ID_PREDECODE_EN
            checks++; if (id_imm_sext !== 32'h5) begin failures++; $display("FAIL stall_imm[%0d] got=%h exp=5", i, id_imm_sext); end
`endif
        end
    endtask

    task automatic test_flush();
        drive(32'h0000_0200, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL flush_inst got=%h exp=0", id_inst); end
        checks++; if (id_pc !== 32'h10) begin failures++; $display("FAIL flush_pc got=%h exp=%h", id_pc, 32'h10); end
        checks++; if (id_pc_plus4 !== 32'h14) begin failures++; $display("FAIL flush_pc4 got=%h exp=%h", id_pc_plus4, 32'h14); end
        checks++; if (bubble_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", bubble_cnt); end
`ifdef IF_ID_PREDECODE_EN
        checks++; if (id_opcode !== 6'h0) begin failures++; $display("FAIL flush_opcode got=%h exp=0", id_opcode); end
        checks++; if (id_rt !== 5'd0) begin failures++; $display("FAIL flush_rt got=%0d exp=0", id_rt); end
        checks++; if (id_imm_sext !== 32'h0) begin failures++; $display("FAIL flush_imm got=%h exp=0", id_imm_sext); end
`endif
    endtask

    task automatic test_invalid_load();
        drive(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (id_pc !== 32'h40) begin failures++; $display("FAIL inv_pc got=%h exp=%h", id_pc, 32'h40); end
        checks++; if (id_pc_plus4 !== 32'h44) begin failures++; $display("FAIL inv_pc4 got=%h exp=%h", id_pc_plus4, 32'h44); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL inv_inst got=%h exp=0", id_inst); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL inv_valid got=%b exp=0", id_valid); end
        checks++; if (bubble_cnt !== 16'd2) begin failures++; $display("FAIL inv_cnt got=%0d exp=2", bubble_cnt); end
    endtask

    task automatic test_wrap();
        drive(32'hFFFF_FFFC, 32'h2008_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", id_pc, 32'hFFFF_FFFC); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", id_pc_plus4); end
        checks++; if (id_inst !== 32'h2008_FFFF) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", id_inst, 32'h2008_FFFF); end
        checks++; if (bubble_cnt !== 16'd2) begin failures++; $display("FAIL wrap_cnt got=%0d exp=2", bubble_cnt); end
`ifdef IF_ID_PREDECODE_EN
        checks++; if (id_imm_sext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_imm got=%h exp=%h", id_imm_sext, 32'hFFFF_FFFF); end
        checks++; if (id_rd !== 5'h1F) begin failures++; $display("FAIL wrap_rd got=%h exp=1f", id_rd); end
        checks++; if (id_shamt !== 5'h1F) begin failures++; $display("FAIL wrap_shamt got=%h exp=1f", id_shamt); end
        checks++; if (id_funct !== 6'h3F) begin failures++; $display("FAIL wrap_funct got=%h exp=3f", id_funct); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(32'h0000_0300, 32'h0123_4567, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rmid_pc got=%h exp=0", id_pc); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rmid_pc4 got=%h exp=0", id_pc_plus4); end
        checks++; if (id_inst !== 32'h0) begin failures++; $display("FAIL rmid_inst got=%h exp=0", id_inst); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", id_valid); end
        checks++; if (bubble_cnt !== 16'h0) begin failures++; $display("FAIL rmid_cnt got=%h exp=0", bubble_cnt); end
`ifdef IF_ID_PREDECODE_EN
        checks++; if (id_imm_sext !== 32'h0) begin failures++; $display("FAIL rmid_imm got=%h exp=0", id_imm_sext); end
        checks++; if (id_rs !== 5'd0) begin failures++; $display("FAIL rmid_rs got=%0d exp=0", id_rs); end
`endif
        tick();
        rst = 1'b0;
        // First edge after reset performs a normal load.
        drive(32'h0000_0100, 32'h0123_4567, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (id_pc !== 32'h100) begin failures++; $display("FAIL post_rst_pc got=%h exp=%h", id_pc, 32'h100); end
        checks++; if (id_pc_plus4 !== 32'h104) begin failures++; $display("FAIL post_rst_pc4 got=%h exp=%h", id_pc_plus4, 32'h104); end
        checks++; if (id_inst !== 32'h0123_4567) begin failures++; $display("FAIL post_rst_inst got=%h exp=%h", id_inst, 32'h0123_4567); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got=%b exp=1", id_valid); end
`ifdef IF_ID_PREDECODE_EN
        checks++; if (id_rs !== 5'd9) begin failures++; $display("FAIL post_rst_rs got=%0d exp=9", id_rs); end
        checks++; if (id_imm_sext !== 32'h0000_4567) begin failures++; $display("FAIL post_rst_imm got=%h exp=%h", id_imm_sext, 32'h4567); end
`endif
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            drive(32'(i * 4), 32'hFACE_0000, 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (s_cnt !== ((i < 15) ? 4'(i) : 4'hF)) begin
                failures++;
                $display("FAIL sat_cnt[%0d] got=%h exp=%h", i, s_cnt, (i < 15) ? 4'(i) : 4'hF);
            end
        end
        checks++; if (bubble_cnt !== 16'd20) begin failures++; $display("FAIL wide_cnt got=%0d exp=20", bubble_cnt); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL sat_valid got=%b exp=0", s_valid); end
        // Stall must not add to a saturated counter nor wrap it.
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bubble_cnt !== 16'd20) begin failures++; $display("FAIL stall_nocnt got=%0d exp=20", bubble_cnt); end
        checks++; if (s_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall got=%h exp=f", s_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush();
        test_invalid_load();
        test_wrap();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
